psi_chunk_sched: RTL and testbench



---
 rtl/psi_pkg.sv | 46 ++++
 rtl/psi_and_core.sv | 49 ++++
 rtl/psi_chunk_sched.sv | 128 ++++++++++++
 tb/tb_psi_chunk_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psi_pkg
// Description : Shared types and helpers for the chunked PSI scheduler and
//               its slice-reducer core (state encoding, sizing, popcount).
// Revision    : 1.0 - initial release
// ============================================================================
package psi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    LAST = 2'd2,
    DONE = 2'd3
  } state_t;

  // Widest chunk the popcount helper is sized for.
  localparam int MAX_CW = 32;

  // Number of chunks in a W-bit job.
  function automatic int nc(input int w, input int cw);
    return w / cw;
  endfunction

  // Width that holds a popcount of 0..w without wrapping.
  function automatic int card_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Chunk index width; a single-chunk job still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Popcount of a chunk, zero-extended into the MAX_CW-wide argument.
  function automatic int unsigned popcount(input logic [MAX_CW-1:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < MAX_CW; i++) begin
      cnt = cnt + {31'd0, v[i]};
    end
    return cnt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psi_and_core.sv
`default_nettype none
// ============================================================================
// Module      : psi_and_core
// Description : Combinational reducer over N party slices of CW bits.
//               Default: strict N-way AND. With PSI_THRESH_EN defined, a
//               result bit is set when at least T of the N party bits are 1.
// Macro       : PSI_THRESH_EN (adds parameter T, default N)
// Revision    : 1.0 - initial release
// ============================================================================
module psi_and_core #(
  parameter int N  = 4,
  parameter int CW = 4
`ifdef PSI_THRESH_EN
  ,
  parameter int T  = N
`endif
) (
  input  logic [N*CW-1:0] i_slices,
  output logic [CW-1:0]   o_result
);

`ifdef PSI_THRESH_EN
  localparam int C_CNT_W = $clog2(N + 1);

  for (genvar b = 0; b < CW; b++) begin : g_bit
    logic [C_CNT_W-1:0] w_cnt;

    // Count how many parties hold this bit position.
    always_comb begin
      w_cnt = '0;
      for (int p = 0; p < N; p++) begin
        w_cnt = w_cnt + C_CNT_W'(i_slices[p*CW+b]);
      end
    end

    assign o_result[b] = (int'(w_cnt) >= T);
  end
`else
  // Bitwise AND across every party slice.
  always_comb begin
    o_result = '1;
    for (int p = 0; p < N; p++) begin
      o_result = o_result & i_slices[p*CW +: CW];
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/psi_chunk_sched.sv
`default_nettype none
// ============================================================================
// Module      : psi_chunk_sched
// Description : Streams a W-bit, N-party PSI job through a CW-bit reducer,
//               one chunk per accepted beat. Registers each chunk result
//               behind a valid/ready output stage and accumulates the
//               running cardinality of emitted intersection bits.
// Macro       : PSI_THRESH_EN (threshold reducer, adds parameter T)
// Revision    : 1.0 - initial release
// ============================================================================
module psi_chunk_sched
  import psi_pkg::*;
#(
  parameter int W  = 16,
  parameter int N  = 4,
  parameter int CW = 4
`ifdef PSI_THRESH_EN
  ,
  parameter int T  = N
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N*CW-1:0]          in_chunk,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CW-1:0]            out_chunk,
  output logic [$clog2(W+1)-1:0]   card,
  output logic                     busy,
  output logic                     done
);

  localparam int C_NC     = nc(W, CW);
  localparam int C_CARD_W = card_w(W);
  localparam int C_IDX_W  = idx_w(C_NC);
  localparam logic [C_IDX_W-1:0] C_IDX_LAST = C_IDX_W'(C_NC - 1);

  state_t                r_state;
  logic [C_IDX_W-1:0]    r_idx;
  logic                  r_out_valid;
  logic [CW-1:0]         r_out_chunk;
  logic [C_CARD_W-1:0]   r_card;

  logic [CW-1:0]         w_result;
  logic [C_CARD_W-1:0]   w_pop;
  logic                  w_in_ready;
  logic                  w_accept;

  psi_and_core #(
    .N  (N),
    .CW (CW)
`ifdef PSI_THRESH_EN
    ,
    .T  (T)
`endif
  ) u_core (
    .i_slices (in_chunk),
    .o_result (w_result)
  );

  // Popcount is zero-extended to card width before accumulation.
  assign w_pop      = C_CARD_W'(popcount(MAX_CW'(w_result)));

  // The output stage can take a new chunk when empty or being drained.
  assign w_in_ready = (r_state == RUN) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;

  // Scheduler FSM: chunk index, output register and cardinality accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_chunk <= '0;
      r_card      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state     <= RUN;
            r_idx       <= '0;
            r_card      <= '0;
            r_out_valid <= 1'b0;
          end
        end
        RUN: begin
          if (w_accept) begin
            r_out_chunk <= w_result;
            r_out_valid <= 1'b1;
            r_card      <= r_card + w_pop;
            if (r_idx == C_IDX_LAST) begin
              r_idx   <= '0;
              r_state <= LAST;
            end else begin
              r_idx   <= r_idx + 1'b1;
            end
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        LAST: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_chunk = r_out_chunk;
  assign card      = r_card;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_psi_chunk_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_psi_chunk_sched
// Description : Self-checking bench for psi_chunk_sched with directed and
//               randomized jobs against a bit-count reference model.
// Macro       : PSI_THRESH_EN (bench runs the DUT with T=3 when defined)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psi_chunk_sched;

  localparam int W      = 16;
  localparam int N      = 4;
  localparam int CW     = 4;
  localparam int NC     = W / CW;
  localparam int CARD_W = $clog2(W + 1);
`ifdef PSI_THRESH_EN
  localparam int TB_T   = 3;
`else
  localparam int TB_T   = N;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [N*CW-1:0]   in_chunk;
  logic              out_valid;
  logic              out_ready;
  logic [CW-1:0]     out_chunk;
  logic [CARD_W-1:0] card;
  logic              busy;
  logic              done;

  int vectors     = 0;
  int miscompares = 0;

  // Job stimulus and results gathered by the driver.
  logic [N*CW-1:0]   job_in [NC];
  logic [CW-1:0]     got_q [$];
  int                acc_cnt, done_cnt, done_cyc, last_take, bp_err, stall_cyc, timeout_f;
  logic [CARD_W-1:0] done_card;

  psi_chunk_sched #(
    .W  (W),
    .N  (N),
    .CW (CW)
`ifdef PSI_THRESH_EN
    ,
    .T  (TB_T)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_chunk  (in_chunk),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_chunk (out_chunk),
    .card      (card),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Reference: a result bit is set when at least TB_T parties have it set.
  function automatic logic [CW-1:0] ref_chunk(input logic [N*CW-1:0] s);
    logic [CW-1:0] r;
    int cnt;
    r = '0;
    for (int b = 0; b < CW; b++) begin
      cnt = 0;
      for (int p = 0; p < N; p++) cnt += int'(s[p*CW+b]);
      r[b] = (cnt >= TB_T);
    end
    return r;
  endfunction

  // Drives one job: mode 0 = ready always, 1 = random valid/ready + stray
  // start, 2 = out_ready low for 3 cycles after the first accept.
  task automatic run_job(input int mode);
    int beat, cyc, first_acc, held;
    logic [CW-1:0] held_chunk;
    logic acc, tk;
    logic [31:0] rnd;
    got_q.delete();
    beat = 0; cyc = 0; first_acc = -1; held = 0; held_chunk = '0;
    done_cnt = 0; done_cyc = -1; last_take = -1; bp_err = 0; stall_cyc = 0;
    timeout_f = 0; done_card = '0;
    @(posedge clk); #1;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (1) begin
      rnd = $urandom;
      in_valid = (beat < NC) && (mode != 1 || $urandom_range(0, 3) != 0);
      in_chunk = (beat < NC) ? job_in[beat] : rnd[N*CW-1:0];
      case (mode)
        1:       out_ready = $urandom_range(0, 1) == 1;
        2:       out_ready = !(first_acc >= 0 && cyc > first_acc && cyc <= first_acc + 3);
        default: out_ready = 1'b1;
      endcase
      start = (mode == 1 && cyc == 2);
      @(negedge clk);
      if (out_valid && !out_ready && in_ready !== 1'b0) bp_err++;
      if (held != 0 && out_chunk !== held_chunk) bp_err++;
      held = (out_valid && !out_ready) ? 1 : 0;
      stall_cyc += held;
      held_chunk = out_chunk;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc  = cyc;
          done_card = card;
        end
      end
      acc = in_valid && in_ready;
      tk  = out_valid && out_ready;
      if (tk) begin
        got_q.push_back(out_chunk);
        last_take = cyc;
      end
      if (acc && first_acc < 0) first_acc = cyc;
      @(posedge clk); #1;
      if (acc) beat++;
      cyc++;
      if (done_cyc >= 0 && cyc > done_cyc + 2) break;
      if (cyc > 300) begin
        timeout_f = 1;
        break;
      end
    end
    acc_cnt  = beat;
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_chunk = '1;
    #12;
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL reset_busy_done: got %b%b want 00", busy, done); end
    vectors++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_hs: got %b%b want 00", in_ready, out_valid); end
    vectors++; if (out_chunk !== '0 || card !== '0) begin miscompares++; $display("FAIL reset_data: got chunk %h card %0d want 0 0", out_chunk, card); end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_idle_ignore;
    int bad;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; out_ready = 1'b1; in_chunk = 16'hFFFF;
      @(negedge clk);
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || card !== '0) bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    vectors++; if (bad !== 0) begin miscompares++; $display("FAIL idle_ignore: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_basic;
    logic [CW-1:0] exp [NC];
    exp = '{4'hF, 4'h0, 4'h0, 4'h0};
    job_in[0] = 16'hFFFF;
    for (int i = 1; i < NC; i++) job_in[i] = 16'h0000;
    run_job(0);
    vectors++; if (timeout_f !== 0 || got_q.size() !== NC) begin miscompares++; $display("FAIL basic_count: got %0d chunks timeout %0d want %0d", got_q.size(), timeout_f, NC); end
    for (int i = 0; i < got_q.size() && i < NC; i++) begin
      vectors++; if (got_q[i] !== exp[i]) begin miscompares++; $display("FAIL basic_chunk%0d: got %h want %h", i, got_q[i], exp[i]); end
    end
    vectors++; if (done_card !== 5'd4) begin miscompares++; $display("FAIL basic_card: got %0d want 4", done_card); end
    vectors++; if (done_cnt !== 1 || done_cyc - last_take !== 1) begin miscompares++; $display("FAIL basic_done: got %0d pulses at +%0d want 1 at +1", done_cnt, done_cyc - last_take); end
    vectors++; if (card !== 5'd4 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_hold: got card %0d busy %b want 4 0", card, busy); end
  endtask

  task automatic test_mixed;
    for (int i = 0; i < NC; i++) job_in[i] = 16'h67EF;
    run_job(0);
    vectors++; if (got_q.size() !== NC) begin miscompares++; $display("FAIL mixed_count: got %0d want %0d", got_q.size(), NC); end
    for (int i = 0; i < got_q.size(); i++) begin
      vectors++; if (got_q[i] !== 4'h6) begin miscompares++; $display("FAIL mixed_chunk%0d: got %h want 6", i, got_q[i]); end
    end
    vectors++; if (done_card !== 5'd8) begin miscompares++; $display("FAIL mixed_card: got %0d want 8", done_card); end
  endtask

  task automatic test_backpressure;
    int exp_card;
    exp_card = 0;
    for (int i = 0; i < NC; i++) begin
      job_in[i] = 16'($urandom) | 16'h1111;
      exp_card += $countones(ref_chunk(job_in[i]));
    end
    run_job(2);
    vectors++; if (stall_cyc < 3 || bp_err !== 0) begin miscompares++; $display("FAIL bp_stall: got %0d stalls %0d errors want >=3 0", stall_cyc, bp_err); end
    vectors++; if (acc_cnt !== NC || got_q.size() !== NC) begin miscompares++; $display("FAIL bp_count: got %0d in %0d out want %0d", acc_cnt, got_q.size(), NC); end
    for (int i = 0; i < got_q.size() && i < NC; i++) begin
      vectors++; if (got_q[i] !== ref_chunk(job_in[i])) begin miscompares++; $display("FAIL bp_chunk%0d: got %h want %h", i, got_q[i], ref_chunk(job_in[i])); end
    end
    vectors++; if (int'(done_card) !== exp_card) begin miscompares++; $display("FAIL bp_card: got %0d want %0d", done_card, exp_card); end
  endtask

  task automatic test_full;
    for (int i = 0; i < NC; i++) job_in[i] = 16'hFFFF;
    run_job(0);
    vectors++; if (done_card !== 5'd16) begin miscompares++; $display("FAIL full_card: got %0d want 16", done_card); end
    vectors++; if (got_q.size() !== NC || got_q[NC-1] !== 4'hF) begin miscompares++; $display("FAIL full_chunks: got %0d chunks want %0d of F", got_q.size(), NC); end
  endtask

  task automatic test_reset_midjob;
    int exp_card;
    @(posedge clk); #1;
    start = 1'b1; out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_chunk = 16'hFFFF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    vectors++; if (card !== 5'd8 || busy !== 1'b1) begin miscompares++; $display("FAIL mid_partial: got card %0d busy %b want 8 1", card, busy); end
    #2 rst = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0 || card !== '0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got busy %b card %0d ov %b ir %b want 0 0 0 0", busy, card, out_valid, in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_card = 0;
    for (int i = 0; i < NC; i++) begin
      job_in[i] = 16'($urandom);
      exp_card += $countones(ref_chunk(job_in[i]));
    end
    run_job(0);
    vectors++; if (got_q.size() !== NC || int'(done_card) !== exp_card) begin miscompares++; $display("FAIL mid_rerun: got %0d chunks card %0d want %0d %0d", got_q.size(), done_card, NC, exp_card); end
  endtask

  task automatic test_random;
    int exp_card;
    logic [3:0] base;
    for (int j = 0; j < 6; j++) begin
      exp_card = 0;
      for (int i = 0; i < NC; i++) begin
        base = 4'($urandom);
        for (int p = 0; p < N; p++) job_in[i][p*CW +: CW] = base | (4'($urandom) & 4'($urandom));
        exp_card += $countones(ref_chunk(job_in[i]));
      end
      run_job(1);
      vectors++; if (timeout_f !== 0 || bp_err !== 0 || done_cnt !== 1) begin miscompares++; $display("FAIL rand%0d_proto: got timeout %0d bp %0d dones %0d want 0 0 1", j, timeout_f, bp_err, done_cnt); end
      vectors++; if (got_q.size() !== NC) begin miscompares++; $display("FAIL rand%0d_count: got %0d want %0d", j, got_q.size(), NC); end
      for (int i = 0; i < got_q.size() && i < NC; i++) begin
        vectors++; if (got_q[i] !== ref_chunk(job_in[i])) begin miscompares++; $display("FAIL rand%0d_chunk%0d: got %h want %h", j, i, got_q[i], ref_chunk(job_in[i])); end
      end
      vectors++; if (int'(done_card) !== exp_card || int'(card) !== exp_card) begin miscompares++; $display("FAIL rand%0d_card: got %0d/%0d want %0d", j, done_card, card, exp_card); end
    end
  endtask

`ifdef PSI_THRESH_EN
  task automatic test_thresh;
    for (int i = 0; i < NC; i++) job_in[i] = 16'h0FFF;
    run_job(0);
    vectors++; if (got_q.size() !== NC || got_q[0] !== 4'hF) begin miscompares++; $display("FAIL thresh_chunk: got %0d chunks want %0d of F", got_q.size(), NC); end
    vectors++; if (done_card !== 5'd16) begin miscompares++; $display("FAIL thresh_card: got %0d want 16", done_card); end
  endtask
`endif

  initial begin
    test_reset();
    test_idle_ignore();
    test_basic();
    test_mixed();
    test_backpressure();
    test_full();
    test_reset_midjob();
    test_random();
`ifdef PSI_THRESH_EN
    test_thresh();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
